uart_tx_mmio: RTL

UART_TX_MMIO -- requirements
Module: uart_tx_mmio

---
 rtl/uart_tx_mmio_pkg.sv | 22 ++
 rtl/uart_tx_mmio_fifo.sv | 60 ++++++
 rtl/uart_tx_mmio.sv | 136 +++++++++++++
 3 files changed

// File: rtl/uart_tx_mmio_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package uart_tx_mmio_pkg;

    typedef logic        u1;
    typedef logic [31:0] u32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam logic [2:0] OFF_TXDATA = 3'd0;
    localparam logic [2:0] OFF_STATUS = 3'd4;

    localparam int STAT_FULL  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_OVF   = 3;

endpackage

// File: rtl/uart_tx_mmio_fifo.sv
// Synchronous FIFO with modulo-DEPTH pointers and an occupancy count one bit wider than the pointers.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full FIFO is legal only when the head leaves on the same edge.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS register window in front of a byte FIFO.
// state | meaning: IDLE wait for FIFO data | START line low | DATA shift LSB first | STOP line high
module uart_tx_mmio
    import uart_tx_mmio_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_FF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataaddr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        hit,
    output logic        tx
);
    localparam int             BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    tx_state_e  state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    u1          ovf_q, ovf_d;

    u1          sel_txdata, sel_status, wr_txdata, wr_status;
    u1          fifo_push, fifo_pop, fifo_full, fifo_empty, ovf_set, busy, baud_last;
    logic [7:0] fifo_head;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    u32         status;
    logic       wdata_unused;

    assign wdata_unused = ^writedata[31:8];

    assign hit        = (dataaddr[31:3] == BASE_ADDR[31:3]);
    assign sel_txdata = hit && (dataaddr[2:0] == OFF_TXDATA);
    assign sel_status = hit && (dataaddr[2:0] == OFF_STATUS);
    assign wr_txdata  = memwrite && sel_txdata;
    assign wr_status  = memwrite && sel_status;

    assign fifo_pop  = (state_q == ST_IDLE) && (fifo_count != '0);
    assign fifo_push = wr_txdata && (!fifo_full || fifo_pop);
    assign ovf_set   = wr_txdata && fifo_full && !fifo_pop;
    // A new overflow wins over a clear landing on the same edge.
    assign ovf_d     = (ovf_q && !wr_status) || ovf_set;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .wdata_i (writedata[7:0]),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        status             = '0;
        status[STAT_FULL]  = fifo_full;
        status[STAT_EMPTY] = fifo_empty;
        status[STAT_BUSY]  = busy;
        status[STAT_OVF]   = ovf_q;
    end

    assign readdata = sel_status ? status : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            ovf_q   <= ovf_d;
        end
    end

    assign baud_last = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_last ? '0 : baud_q + BW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        unique case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (fifo_pop) begin
                    state_d = ST_START;
                    shift_d = fifo_head;
                    bit_d   = '0;
                end
            end
            ST_START: begin
                if (baud_last) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (baud_last) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (baud_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx   = 1'b1;
        busy = (state_q != ST_IDLE);
        unique case (state_q)
            ST_START: tx = 1'b0;
            ST_DATA:  tx = shift_q[0];
            default:  tx = 1'b1;
        endcase
    end

endmodule
